sad_accum_select: RTL and testbench
===================================

# sad_accum_select

Accumulates per-line absolute differences for the 25 fractional-pel candidates of an 8x8 block and selects the minimum-SAD candidate. Sits directly downstream of the per-line absolute-difference stage of the fractional motion-estimation path. It consumes one line of differences per accepted beat and emits the winning quarter-pel motion vector with its SAD.

## Interface
- LINES, 8, lines per block (power of two)
- PIX, 8, pixels per line (power of two)
- ACC_W, 8+log2(PIX)+log2(LINES) = 14, SAD accumulator width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  diff_in carries a valid line
- in_ready  output  1  block accepts a line this cycle
- diff_in  input  25*PIX*8  candidate c occupies bits [c*PIX*8 +: PIX*8]; byte p is the absolute difference of pixel p
- out_valid  output  1  result valid, held until accepted
- out_ready  input  1  consumer accepts result
- best_idx  output  5  winning candidate index, 0..24
- best_sad  output  ACC_W  winning SAD
- mv_x  output  3  signed quarter-pel horizontal offset
- mv_y  output  3  signed quarter-pel vertical offset

## Operation
- Candidate c: row r=c/5 (0=UH, 1=UQ, 2=M, 3=LQ, 4=LH), column k=c%5; mv_y=r-2, mv_x=k-2, both two's complement. Index 12 is the full-pel centre.
- States: ACCUM, SEARCH, DONE. Reset state is ACCUM with line_cnt=0.
- ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready.
  - Per candidate, the line sum is the sum of PIX bytes, zero-extended; the result is 11 bits for PIX=8.
  - When line_cnt=0, acc[c] is loaded with the line sum. Otherwise acc[c] += line sum.
  - Accumulation cannot overflow: the maximum is 255*64 = 16320, which is less than 2^14.
  - line_cnt increments on each accepted beat. The accept at line_cnt=LINES-1 moves to SEARCH and resets line_cnt to 0.
  - in_valid gaps are allowed. acc and line_cnt hold while no beat is accepted.
- SEARCH: in_ready=0. One candidate per cycle, 25 cycles, using a sequential comparator.
  - The first scanned candidate loads best_sad/best_idx unconditionally.
  - Each later candidate replaces the best only if acc < best_sad (strict less-than).
  - Scan order is set by the configuration macro (see Configuration).
  - After the 25th compare, the state moves to DONE.
- DONE: out_valid=1; best_idx, best_sad, mv_x and mv_y are stable and registered.
  - When out_valid&out_ready, the state moves to ACCUM. out_valid drops the next cycle.
  - Outputs keep their last values until the next SEARCH overwrites them.
- Reset, including mid-ACCUM or mid-SEARCH, discards all partial state. No leftover accumulation reaches the next block.

## Timing
- Reset values: in_ready=1 (state ACCUM), out_valid=0, best_idx=0, best_sad=0, mv_x=0, mv_y=0.
- Let the last line of a block be accepted in cycle N. SEARCH then occupies cycles N+1..N+25, and out_valid=1 from cycle N+26.
- Handshake at cycle M: in_ready=1 from cycle M+1, and a new first line can be accepted in M+1.
- Minimum block period is LINES+26 cycles (34 for the defaults), with out_ready tied high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- in_ready is decoded from the state register only.

## Configuration
- SAD_CENTER_PREF_EN defined:
  - Scan order is 12, then 0..11, then 13..24.
  - Ties resolve to the centre candidate 12 when it is among the minimum. Otherwise they resolve to the lowest index.
- SAD_CENTER_PREF_EN undefined:
  - Scan order is 0..24.
  - Ties always resolve to the lowest index.
- Latency is identical in both builds.

## Test plan
- Minimum at candidate 7: all bytes of all candidates =10, except candidate 7 bytes =3, over 8 lines. Required response: best_idx=7, best_sad=192, mv_y=-1, mv_x=0, out_valid exactly 26 cycles after the 8th accept.
- Full-scale tie: all bytes =255. Required response: best_sad=16320 (no overflow). With the macro, best_idx=12 and mv=(0,0). Without it, best_idx=0 and mv_x=-2, mv_y=-2.
- Bubbles: the same stimulus as the candidate-7 case, with in_valid low for 1–3 cycles between lines. Required response: identical result, out_valid 26 cycles after the last accept.
- Backpressure: out_ready low for 10 cycles after out_valid rises. Required response: outputs stable, in_ready=0, in_valid ignored. Raise out_ready: out_valid=0 and in_ready=1 the next cycle.
- Reset mid-SEARCH: assert rst at the 10th SEARCH cycle. Required response: all outputs return to reset values immediately. A following block where only candidate 24 has byte values =0 and all others =1 gives best_idx=24, best_sad=0, mv=(2,2).
- Back-to-back blocks with out_ready=1: block A has the minimum at 3, block B the minimum at 20. Required response: results 3 then 20. Block B's first line is accepted one cycle after A's handshake, with no carry-over into B's SAD.

Source files
------------

// File: rtl/sad_accum_select.sv
// Accumulates 8x8 block SADs for 25 quarter-pel candidates, then scans them sequentially for the minimum.
// Optional build macro SAD_CENTER_PREF_EN: scan the full-pel centre first so ties favour it.
module sad_accum_select #(
  parameter int LINES = 8,
  parameter int PIX   = 8,
  parameter int ACC_W = 8 + $clog2(PIX) + $clog2(LINES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [25*PIX*8-1:0] diff_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         best_idx,
  output logic [ACC_W-1:0]   best_sad,
  output logic [2:0]         mv_x,
  output logic [2:0]         mv_y
);

  localparam int NCAND = 25;
  localparam int SUM_W = 8 + $clog2(PIX);
  localparam int CNT_W = $clog2(LINES);

  typedef enum logic [1:0] {ACCUM, SEARCH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] line_cnt;
  logic [4:0]       scan_cnt;
  logic [ACC_W-1:0] acc [NCAND];
  logic [SUM_W-1:0] line_sum [NCAND];
  logic [4:0]       scan_idx;
  logic [2:0]       scan_row;
  logic [2:0]       scan_col;
  logic [2:0]       scan_mv_x;
  logic [2:0]       scan_mv_y;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  always_comb begin
    for (int c = 0; c < NCAND; c++) begin
      line_sum[c] = '0;
      for (int p = 0; p < PIX; p++) begin
        line_sum[c] = line_sum[c] + SUM_W'(diff_in[c*PIX*8 + p*8 +: 8]);
      end
    end
  end

  // Map scan step to candidate index, then index to its quarter-pel vector.
  always_comb begin
`ifdef SAD_CENTER_PREF_EN
    if (scan_cnt == 5'd0)
      scan_idx = 5'd12;
    else if (scan_cnt <= 5'd12)
      scan_idx = scan_cnt - 5'd1;
    else
      scan_idx = scan_cnt;
`else
    scan_idx = scan_cnt;
`endif
    scan_row = 3'd0;
    if (scan_idx >= 5'd20)
      scan_row = 3'd4;
    else if (scan_idx >= 5'd15)
      scan_row = 3'd3;
    else if (scan_idx >= 5'd10)
      scan_row = 3'd2;
    else if (scan_idx >= 5'd5)
      scan_row = 3'd1;
    scan_col  = 3'(scan_idx - {scan_row, 2'b00} - {2'b00, scan_row});
    scan_mv_y = scan_row - 3'd2;
    scan_mv_x = scan_col - 3'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      line_cnt <= '0;
      scan_cnt <= '0;
      best_idx <= '0;
      best_sad <= '0;
      mv_x     <= '0;
      mv_y     <= '0;
      for (int c = 0; c < NCAND; c++) acc[c] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            // First line of a block loads, so nothing from a previous block survives.
            for (int c = 0; c < NCAND; c++) begin
              if (line_cnt == '0)
                acc[c] <= ACC_W'(line_sum[c]);
              else
                acc[c] <= acc[c] + ACC_W'(line_sum[c]);
            end
            if (line_cnt == CNT_W'(LINES - 1)) begin
              line_cnt <= '0;
              scan_cnt <= '0;
              state    <= SEARCH;
            end else begin
              line_cnt <= line_cnt + CNT_W'(1);
            end
          end
        end
        SEARCH: begin
          if (scan_cnt == 5'd0 || acc[scan_idx] < best_sad) begin
            best_sad <= acc[scan_idx];
            best_idx <= scan_idx;
            mv_x     <= scan_mv_x;
            mv_y     <= scan_mv_y;
          end
          if (scan_cnt == 5'd24) begin
            scan_cnt <= '0;
            state    <= DONE;
          end else begin
            scan_cnt <= scan_cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_accum_select.sv
// Randomised and directed bench for sad_accum_select against a whole-block SAD/argmin model.
// Honours SAD_CENTER_PREF_EN for the tie rule so it matches either build.
module tb_sad_accum_select;

  localparam int LINES = 8;
  localparam int PIX   = 8;
  localparam int ACC_W = 14;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [25*PIX*8-1:0]  diff_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           best_idx;
  logic [ACC_W-1:0]     best_sad;
  logic [2:0]           mv_x;
  logic [2:0]           mv_y;

  sad_accum_select #(.LINES(LINES), .PIX(PIX), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .diff_in(diff_in),
    .out_valid(out_valid), .out_ready(out_ready), .best_idx(best_idx), .best_sad(best_sad),
    .mv_x(mv_x), .mv_y(mv_y)
  );

  logic [7:0] blk [LINES][25][PIX];
  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int first_accept, last_accept, hs_cyc;
  int exp_idx, exp_sad, exp_mv_x, exp_mv_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic fillConst(input int v);
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < 25; c++)
        for (int p = 0; p < PIX; p++) blk[l][c][p] = 8'(v);
  endtask

  task automatic setCand(input int cand, input int v);
    for (int l = 0; l < LINES; l++)
      for (int p = 0; p < PIX; p++) blk[l][cand][p] = 8'(v);
  endtask

  task automatic fillRandom(input int lo, input int hi);
    for (int l = 0; l < LINES; l++)
      for (int c = 0; c < 25; c++)
        for (int p = 0; p < PIX; p++) blk[l][c][p] = 8'($urandom_range(hi, lo));
  endtask

  // Reference: total SAD per candidate over the block, then the argmin with the build's tie rule.
  task automatic computeExpected();
    int sad [25];
    int min_v;
    for (int c = 0; c < 25; c++) begin
      sad[c] = 0;
      for (int l = 0; l < LINES; l++)
        for (int p = 0; p < PIX; p++) sad[c] += int'(blk[l][c][p]);
    end
    min_v = sad[0];
    for (int c = 1; c < 25; c++) if (sad[c] < min_v) min_v = sad[c];
    exp_idx = -1;
    for (int c = 0; c < 25; c++) if (exp_idx < 0 && sad[c] == min_v) exp_idx = c;
`ifdef SAD_CENTER_PREF_EN
    if (sad[12] == min_v) exp_idx = 12;
`endif
    exp_sad  = min_v;
    exp_mv_y = exp_idx / 5 - 2;
    exp_mv_x = exp_idx % 5 - 2;
  endtask

  // Sends the LINES lines of blk, with min_gap..max_gap idle cycles before each; starts and ends at a negedge.
  task automatic applyStimulus(input int min_gap, input int max_gap);
    for (int l = 0; l < LINES; l++) begin
      int gap;
      int n;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      for (int c = 0; c < 25; c++)
        for (int p = 0; p < PIX; p++) diff_in[c*PIX*8 + p*8 +: 8] = blk[l][c][p];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
      @(negedge clk);
      if (l == 0) first_accept = cyc;
      last_accept = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic collectResult(input int hold);
    int n;
    computeExpected();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checkOutput("out_valid_timeout", 0, 1);
    end else begin
      checkOutput("latency", cyc - last_accept, 25);
      checkOutput("best_idx", int'(best_idx), exp_idx);
      checkOutput("best_sad", int'(best_sad), exp_sad);
      checkOutput("mv_x", int'($signed(mv_x)), exp_mv_x);
      checkOutput("mv_y", int'($signed(mv_y)), exp_mv_y);
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        for (int w = 0; w < 25*PIX*8/32; w++) diff_in[w*32 +: 32] = $urandom;
        @(negedge clk);
        checkOutput("bp_out_valid", int'(out_valid), 1);
        checkOutput("bp_in_ready", int'(in_ready), 0);
        checkOutput("bp_best_idx", int'(best_idx), exp_idx);
        checkOutput("bp_best_sad", int'(best_sad), exp_sad);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      hs_cyc    = cyc + 1;
      @(negedge clk);
      checkOutput("post_hs_out_valid", int'(out_valid), 0);
      checkOutput("post_hs_in_ready", int'(in_ready), 1);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_best_idx"}, int'(best_idx), 0);
    checkOutput({tag, "_best_sad"}, int'(best_sad), 0);
    checkOutput({tag, "_mv_x"}, int'(mv_x), 0);
    checkOutput({tag, "_mv_y"}, int'(mv_y), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    diff_in   = '0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] minimum at candidate 7");
    fillConst(10);
    setCand(7, 3);
    applyStimulus(0, 0);
    collectResult(0);
    checkOutput("c7_sad_const", exp_sad, 192);

    $display("[TB] full-scale tie");
    fillConst(255);
    applyStimulus(0, 0);
    collectResult(0);
    checkOutput("tie_sad_const", int'(best_sad), 16320);

    $display("[TB] bubbles with backpressure");
    fillConst(10);
    setCand(7, 3);
    out_ready = 1'b0;
    applyStimulus(1, 3);
    collectResult(10);

    $display("[TB] reset mid-search");
    fillRandom(1, 255);
    applyStimulus(0, 0);
    repeat (9) @(negedge clk);
    checkOutput("search_in_ready", int'(in_ready), 0);
    checkOutput("search_out_valid", int'(out_valid), 0);
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fillConst(1);
    setCand(24, 0);
    applyStimulus(0, 0);
    collectResult(0);
    checkOutput("c24_idx_const", int'(best_idx), 24);

    $display("[TB] back-to-back blocks");
    fillConst(10);
    setCand(3, 5);
    applyStimulus(0, 0);
    collectResult(0);
    fillConst(10);
    setCand(20, 2);
    applyStimulus(0, 0);
    checkOutput("b2b_first_accept", first_accept, hs_cyc + 1);
    collectResult(0);
    checkOutput("b2b_sad_const", int'(best_sad), 128);

    $display("[TB] random blocks");
    for (int t = 0; t < 8; t++) begin
      int hold;
      hold = int'($urandom_range(3, 0));
      if (t % 2 == 0) fillRandom(0, 3);
      else fillRandom(0, 255);
      out_ready = (hold == 0);
      applyStimulus(0, 2);
      collectResult(hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
